// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - sequential MUL/MULHU/DIVU/REMU unit, one adder reused over WIDTH steps
// Divide datapath compiled only when MULDIV_DIV_EN is defined; otherwise op 10/11 return 0 at full latency.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic [WIDTH:0]     add_a;
  logic [WIDTH:0]     add_b;
  logic               add_cin;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH-1:0]   hi_step;
  logic [WIDTH-1:0]   lo_step;
  logic [WIDTH-1:0]   sel_result;

  // hi/lo hold {product_hi, multiplier} for multiply and {remainder, quotient} for divide.
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] rem_sh;

  always_comb begin
    rem_sh  = {hi_q, lo_q[WIDTH-1]};
    add_a   = {1'b0, hi_q};
    add_b   = {1'b0, (lo_q[0] ? opnd_q : {WIDTH{1'b0}})};
    add_cin = 1'b0;
    if (op_q[1]) begin
      add_a   = rem_sh;
      add_b   = ~{1'b0, opnd_q};
      add_cin = 1'b1;
    end
  end

  always_comb begin
    add_sum = add_a + add_b + {{WIDTH{1'b0}}, add_cin};
    hi_step = add_sum[WIDTH:1];
    lo_step = {add_sum[0], lo_q[WIDTH-1:1]};
    if (op_q[1]) begin
      // A clear sign bit means the trial subtraction did not borrow.
      if (!add_sum[WIDTH]) begin
        hi_step = add_sum[WIDTH-1:0];
        lo_step = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_step = rem_sh[WIDTH-1:0];
        lo_step = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    sel_result = op_q[0] ? hi_q : lo_q;
  end
`else
  always_comb begin
    add_a   = {1'b0, hi_q};
    add_b   = {1'b0, (lo_q[0] ? opnd_q : {WIDTH{1'b0}})};
    add_cin = 1'b0;
  end

  always_comb begin
    add_sum = add_a + add_b + {{WIDTH{1'b0}}, add_cin};
    hi_step = add_sum[WIDTH:1];
    lo_step = {add_sum[0], lo_q[WIDTH-1:1]};
  end

  always_comb begin
    sel_result = op_q[1] ? {WIDTH{1'b0}} : (op_q[0] ? hi_q : lo_q);
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          state_d = S_RUN;
          cnt_d   = CNT_W'(WIDTH);
          op_d    = op;
          hi_d    = {WIDTH{1'b0}};
`ifdef MULDIV_DIV_EN
          lo_d    = op[1] ? a : b;
          opnd_d  = op[1] ? b : a;
`else
          lo_d    = b;
          opnd_d  = a;
`endif
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          hi_d  = hi_step;
          lo_d  = lo_step;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!flush) begin
          result_d = sel_result;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The done-cycle result is driven straight from hi/lo so a flush there leaves result untouched.
  always_comb begin
    busy   = (state_q == S_RUN);
    done   = (state_q == S_DONE) && !flush;
    result = done ? sel_result : result_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - scoreboard bench for alu_muldiv_seq (expects divide results only with MULDIV_DIV_EN)
module tb_alu_muldiv_seq;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          flush;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    int           due;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  int           busy_cnt = 0;
  logic [W-1:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    case (o)
      2'd0: return p[W-1:0];
      2'd1: return p[2*W-1:W];
`ifdef MULDIV_DIV_EN
      2'd2: return (y == 0) ? {W{1'b1}} : x / y;
      2'd3: return (y == 0) ? x : x % y;
`endif
      default: return '0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (done) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_done observed=%h expected=no_done", result);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks += 3;
        assert (result === e.res) else begin
          errors++;
          $error("FAIL result observed=%h expected=%h", result, e.res);
        end
        assert (cyc === e.due) else begin
          errors++;
          $error("FAIL latency observed=%0d expected=%0d", cyc, e.due);
        end
        assert (busy_cnt === W) else begin
          errors++;
          $error("FAIL busy_cycles observed=%0d expected=%0d", busy_cnt, W);
        end
        last_res = e.res;
      end
    end
    if (busy) busy_cnt++;
    else busy_cnt = 0;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    if (push) sb.push_back('{res: model(o, x, y), due: cyc + LAT});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout observed=%0d pending expected=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    issue(o, x, y, 1'b1);
    wait_drain();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op = 2'd0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;

    run_op(2'd0, 32'd7, 32'd6);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'd2, 32'd100, 32'd7);
    run_op(2'd3, 32'd100, 32'd7);
    run_op(2'd2, 32'd5, 32'd0);
    run_op(2'd3, 32'd5, 32'd0);
    for (int i = 0; i < 8; i++) begin
      logic [1:0]   ro;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 1) rb = rb >> 20;
      run_op(ro, ra, rb);
    end

    // Stray start and operand changes while running must be ignored.
    issue(2'd0, 32'd3, 32'd4, 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1;
    op = 2'd2;
    a = 32'd9;
    b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    wait_drain();
    repeat (40) @(negedge clk);
    check("ignored_start_idle", {31'b0, busy}, 32'd0);

    // Flush in RUN cycle 10.
    issue(2'd0, 32'd7, 32'd6, 1'b0);
    repeat (9) @(negedge clk);
    check("flush_busy_before", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_after", {31'b0, busy}, 32'd0);
    check("flush_result_hold", result, last_res);
    check("flush_no_done", {31'b0, done}, 32'd0);
    repeat (40) @(negedge clk);
    check("flush_result_later", result, last_res);

    // Flush wins over start in IDLE.
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    op = 2'd0;
    a = 32'd5;
    b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("flush_start_busy", {31'b0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("flush_start_result", result, last_res);

    // Reset in RUN cycle 5.
    issue(2'd0, 32'd8, 32'd8, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    run_op(2'd0, 32'd2, 32'd3);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
